// File: rtl/gau_pkg.sv
// Shared types for the colour-adjust arbiter: grant states, pixel payload and
// the per-stage pipeline records.
package gau_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
    logic [PIX_W-1:0] gray;
  } pix_t;

  // Operand stage: what the shared unit sees plus routing/control bits
  typedef struct packed {
    pix_t pix;
    logic id;
    logic last;
    logic bypass;
  } s1_t;

  // Result stage: adjusted (or bypassed) colour plus routing bits
  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
    logic             id;
    logic             last;
  } s2_t;

  localparam int unsigned S1_W = $bits(s1_t);
  localparam int unsigned S2_W = $bits(s2_t);

endpackage

// File: rtl/gau_share_arb_if.sv
// Requester, shared-unit and response signals of the colour-adjust arbiter.
// master = surrounding parent/requesters, slave = the arbiter.
interface gau_share_arb_if;

  logic                      iBypass;

  logic                      iReq0_valid;
  logic                      oReq0_ready;
  logic [gau_pkg::PIX_W-1:0] iReq0_R;
  logic [gau_pkg::PIX_W-1:0] iReq0_G;
  logic [gau_pkg::PIX_W-1:0] iReq0_B;
  logic [gau_pkg::PIX_W-1:0] iReq0_gray;
  logic                      iReq0_last;

  logic                      iReq1_valid;
  logic                      oReq1_ready;
  logic [gau_pkg::PIX_W-1:0] iReq1_R;
  logic [gau_pkg::PIX_W-1:0] iReq1_G;
  logic [gau_pkg::PIX_W-1:0] iReq1_B;
  logic [gau_pkg::PIX_W-1:0] iReq1_gray;
  logic                      iReq1_last;

  logic [gau_pkg::PIX_W-1:0] oDp_R;
  logic [gau_pkg::PIX_W-1:0] oDp_G;
  logic [gau_pkg::PIX_W-1:0] oDp_B;
  logic [gau_pkg::PIX_W-1:0] oDp_gray;
  logic [gau_pkg::PIX_W-1:0] iDp_R;
  logic [gau_pkg::PIX_W-1:0] iDp_G;
  logic [gau_pkg::PIX_W-1:0] iDp_B;

  logic                      oRsp_valid;
  logic                      iRsp_ready;
  logic [gau_pkg::PIX_W-1:0] oRsp_R;
  logic [gau_pkg::PIX_W-1:0] oRsp_G;
  logic [gau_pkg::PIX_W-1:0] oRsp_B;
  logic                      oRsp_id;
  logic                      oRsp_last;

  modport master (
    output iBypass,
    output iReq0_valid, iReq0_R, iReq0_G, iReq0_B, iReq0_gray, iReq0_last,
    output iReq1_valid, iReq1_R, iReq1_G, iReq1_B, iReq1_gray, iReq1_last,
    output iDp_R, iDp_G, iDp_B,
    output iRsp_ready,
    input  oReq0_ready, oReq1_ready,
    input  oDp_R, oDp_G, oDp_B, oDp_gray,
    input  oRsp_valid, oRsp_R, oRsp_G, oRsp_B, oRsp_id, oRsp_last
  );

  modport slave (
    input  iBypass,
    input  iReq0_valid, iReq0_R, iReq0_G, iReq0_B, iReq0_gray, iReq0_last,
    input  iReq1_valid, iReq1_R, iReq1_G, iReq1_B, iReq1_gray, iReq1_last,
    input  iDp_R, iDp_G, iDp_B,
    input  iRsp_ready,
    output oReq0_ready, oReq1_ready,
    output oDp_R, oDp_G, oDp_B, oDp_gray,
    output oRsp_valid, oRsp_R, oRsp_G, oRsp_B, oRsp_id, oRsp_last
  );

endinterface

// File: rtl/gau_pipe_reg.sv
// One valid/ready register slice; the caller computes the enable so a chain of
// these forms a stall-able pipeline.
module gau_pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_v,
  input  logic [W-1:0] in_d,
  output logic         out_v,
  output logic [W-1:0] out_d
);

  // Data only moves with a valid beat so held results stay put across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v <= 1'b0;
      out_d <= '0;
    end else if (en) begin
      out_v <= in_v;
      if (in_v) out_d <= in_d;
    end
  end

endmodule

// File: rtl/gau_share_arb.sv
// Line-granular round-robin arbiter sharing one combinational colour-adjust
// unit between two pixel streams, with operand and result register stages.
module gau_share_arb
  import gau_pkg::*;
#(
  parameter  int unsigned MAX_BURST = 640,
  localparam int unsigned CW        = $clog2(MAX_BURST)
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  gau_share_arb_if.slave  bus
);

  state_e          state_q;
  state_e          state_d;
  logic            rr_q;
  logic [CW-1:0]   cnt_q;

  logic            s1_v;
  logic            s2_v;
  s1_t             s1_d;
  s1_t             s1_q;
  s2_t             s2_d;
  s2_t             s2_q;

  logic            s1_en;
  logic            s2_en;
  logic            ready0_c;
  logic            ready1_c;
  logic            acc_c;
  logic            acc_last_c;
  logic            release_c;

  // Pipeline advance: a stage may load when empty or when its consumer drains it
  assign s2_en = !s2_v || bus.iRsp_ready;
  assign s1_en = !s1_v || s2_en;

  assign acc_c      = (ready0_c && bus.iReq0_valid) || (ready1_c && bus.iReq1_valid);
  assign acc_last_c = (state_q == GRANT1) ? bus.iReq1_last : bus.iReq0_last;
  assign release_c  = acc_c && (acc_last_c || (cnt_q == CW'(MAX_BURST - 1)));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.iReq0_valid && bus.iReq1_valid) state_d = rr_q ? GRANT1 : GRANT0;
        else if (bus.iReq0_valid)               state_d = GRANT0;
        else if (bus.iReq1_valid)               state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (release_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // IDLE grants nobody, which is the one-cycle bubble between lines
  always_comb begin
    ready0_c = 1'b0;
    ready1_c = 1'b0;
    case (state_q)
      GRANT0:  ready0_c = s1_en;
      GRANT1:  ready1_c = s1_en;
      default: begin
        ready0_c = 1'b0;
        ready1_c = 1'b0;
      end
    endcase
  end

  assign bus.oReq0_ready = ready0_c;
  assign bus.oReq1_ready = ready1_c;

  // Beat counter and round-robin pointer; release hands priority to the other port
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q <= '0;
      rr_q  <= 1'b0;
    end else if (release_c) begin
      cnt_q <= '0;
      rr_q  <= (state_q == GRANT0);
    end else if (acc_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_comb begin
    s1_d        = '0;
    s1_d.id     = (state_q == GRANT1);
    s1_d.bypass = bus.iBypass;
    if (state_q == GRANT1) begin
      s1_d.pix  = '{r: bus.iReq1_R, g: bus.iReq1_G, b: bus.iReq1_B, gray: bus.iReq1_gray};
      s1_d.last = bus.iReq1_last;
    end else begin
      s1_d.pix  = '{r: bus.iReq0_R, g: bus.iReq0_G, b: bus.iReq0_B, gray: bus.iReq0_gray};
      s1_d.last = bus.iReq0_last;
    end
  end

  gau_pipe_reg #(.W(S1_W)) u_s1 (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .en    (s1_en),
    .in_v  (acc_c),
    .in_d  (s1_d),
    .out_v (s1_v),
    .out_d (s1_q)
  );

  assign bus.oDp_R    = s1_q.pix.r;
  assign bus.oDp_G    = s1_q.pix.g;
  assign bus.oDp_B    = s1_q.pix.b;
  assign bus.oDp_gray = s1_q.pix.gray;

  always_comb begin
    s2_d      = '0;
    s2_d.r    = s1_q.bypass ? s1_q.pix.r : bus.iDp_R;
    s2_d.g    = s1_q.bypass ? s1_q.pix.g : bus.iDp_G;
    s2_d.b    = s1_q.bypass ? s1_q.pix.b : bus.iDp_B;
    s2_d.id   = s1_q.id;
    s2_d.last = s1_q.last;
  end

  gau_pipe_reg #(.W(S2_W)) u_s2 (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .en    (s2_en),
    .in_v  (s1_v),
    .in_d  (s2_d),
    .out_v (s2_v),
    .out_d (s2_q)
  );

  assign bus.oRsp_valid = s2_v;
  assign bus.oRsp_R     = s2_q.r;
  assign bus.oRsp_G     = s2_q.g;
  assign bus.oRsp_B     = s2_q.b;
  assign bus.oRsp_id    = s2_q.id;
  assign bus.oRsp_last  = s2_q.last;

endmodule

// File: tb/tb_gau_share_arb.sv
// Self-checking bench for gau_share_arb: directed table, hand-written corner
// sequences and randomized traffic against a line/beat-level scoreboard.
module tb_gau_share_arb;

  localparam int unsigned MAXB = 4;

  logic clk;
  logic rst_n;

  gau_share_arb_if bus();

  gau_share_arb #(.MAX_BURST(MAXB)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the parent's colour-adjust unit: brighten by gray/10, saturating
  function automatic logic [7:0] adj(input logic [7:0] x, input logic [7:0] gray);
    int s;
    s = int'(x) + int'(gray) / 10;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  assign bus.iDp_R = adj(bus.oDp_R, bus.oDp_gray);
  assign bus.iDp_G = adj(bus.oDp_G, bus.oDp_gray);
  assign bus.iDp_B = adj(bus.oDp_B, bus.oDp_gray);

  typedef struct { logic [7:0] r, g, b, gray; logic last; } beat_t;
  typedef struct { logic [7:0] r, g, b; logic last; } exp_t;
  typedef struct {
    int port; logic [7:0] r, g, b, gray; logic byp;
    logic [7:0] er, eg, eb;
  } vec_t;

  int checks = 0;
  int failures = 0;

  beat_t q0[$], q1[$];
  exp_t  e0[$], e1[$];
  int    acc_id_log[$], acc_cyc_log[$], rsp_id_log[$], rsp_cyc_log[$];
  int unsigned valid_pct[2];
  int unsigned rdy_pct;
  int    byp_mode;
  int    cyc;
  int    run_len, owner;
  logic  rel_prev, hold_v;
  logic [31:0] hold_word;
  logic [7:0]  last_r, last_g, last_b;
  logic        last_id, last_last, smp_rdy0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    acc_id_log.delete(); acc_cyc_log.delete(); rsp_id_log.delete(); rsp_cyc_log.delete();
    run_len = 0; owner = -1; rel_prev = 1'b0; hold_v = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.iReq0_valid = 1'b0;
    bus.iReq1_valid = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_line(input int port, input int len, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b, input logic [7:0] gray);
    beat_t bt;
    for (int i = 0; i < len; i++) begin
      bt = '{r: r, g: g, b: b, gray: gray, last: (i == len - 1)};
      if (port == 0) q0.push_back(bt); else q1.push_back(bt);
    end
  endtask

  // One clock of traffic: drive at negedge, sample just after, score, then cross posedge
  task automatic step();
    logic  a0, a1, id;
    beat_t bt;
    exp_t  ex;
    int    inflight;
    @(negedge clk);
    bus.iReq0_valid = (q0.size() > 0) && ($urandom_range(99) < valid_pct[0]);
    bus.iReq1_valid = (q1.size() > 0) && ($urandom_range(99) < valid_pct[1]);
    if (q0.size() > 0) begin
      bus.iReq0_R = q0[0].r; bus.iReq0_G = q0[0].g; bus.iReq0_B = q0[0].b;
      bus.iReq0_gray = q0[0].gray; bus.iReq0_last = q0[0].last;
    end
    if (q1.size() > 0) begin
      bus.iReq1_R = q1[0].r; bus.iReq1_G = q1[0].g; bus.iReq1_B = q1[0].b;
      bus.iReq1_gray = q1[0].gray; bus.iReq1_last = q1[0].last;
    end
    bus.iBypass    = (byp_mode == 2) ? 1'($urandom_range(1)) : (byp_mode == 1);
    bus.iRsp_ready = ($urandom_range(99) < rdy_pct);
    #1;
    cyc++;
    smp_rdy0 = bus.oReq0_ready;
    chk("ready_exclusive", 32'(bus.oReq0_ready & bus.oReq1_ready), 32'd0);
    if (rel_prev) chk("bubble_after_release", 32'(bus.oReq0_ready | bus.oReq1_ready), 32'd0);
    rel_prev = 1'b0;
    if (hold_v) begin
      chk("hold_valid", 32'(bus.oRsp_valid), 32'd1);
      chk("hold_data", 32'({bus.oRsp_R, bus.oRsp_G, bus.oRsp_B, bus.oRsp_id, bus.oRsp_last}), hold_word);
    end
    inflight = e0.size() + e1.size();
    chk("in_flight_le2", 32'(inflight <= 2), 32'd1);
    a0 = bus.iReq0_valid && bus.oReq0_ready;
    a1 = bus.iReq1_valid && bus.oReq1_ready;
    if (a0 || a1) begin
      id = a1;
      bt = a1 ? q1[0] : q0[0];
      ex.r = bus.iBypass ? bt.r : adj(bt.r, bt.gray);
      ex.g = bus.iBypass ? bt.g : adj(bt.g, bt.gray);
      ex.b = bus.iBypass ? bt.b : adj(bt.b, bt.gray);
      ex.last = bt.last;
      if (id) e1.push_back(ex); else e0.push_back(ex);
      acc_id_log.push_back(int'(id));
      acc_cyc_log.push_back(cyc);
      if (owner >= 0 && run_len != 0) chk("line_not_interleaved", 32'(id), 32'(owner));
      owner = int'(id);
      run_len++;
      chk("burst_within_cap", 32'(run_len <= int'(MAXB)), 32'd1);
      if (bt.last || run_len == int'(MAXB)) begin
        run_len  = 0;
        rel_prev = 1'b1;
      end
    end
    if (bus.oRsp_valid && bus.iRsp_ready) begin
      if ((bus.oRsp_id ? e1.size() : e0.size()) == 0) begin
        chk("rsp_expected", 32'd0, 32'd1);
      end else begin
        ex = bus.oRsp_id ? e1.pop_front() : e0.pop_front();
        chk("rsp_data", 32'({bus.oRsp_R, bus.oRsp_G, bus.oRsp_B, bus.oRsp_last}),
            32'({ex.r, ex.g, ex.b, ex.last}));
      end
      last_r = bus.oRsp_R; last_g = bus.oRsp_G; last_b = bus.oRsp_B;
      last_id = bus.oRsp_id; last_last = bus.oRsp_last;
      rsp_id_log.push_back(int'(bus.oRsp_id));
      rsp_cyc_log.push_back(cyc);
    end
    hold_v    = bus.oRsp_valid && !bus.iRsp_ready;
    hold_word = 32'({bus.oRsp_R, bus.oRsp_G, bus.oRsp_B, bus.oRsp_id, bus.oRsp_last});
    @(posedge clk);
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
  endtask

  task automatic run_until_idle(input int bound);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + e0.size() + e1.size()) > 0 && n < bound) begin
      step();
      n++;
    end
    chk("drained_in_budget", 32'((q0.size() + q1.size() + e0.size() + e1.size()) == 0), 32'd1);
  endtask

  vec_t vecs[6];
  int   exp_ids[$];

  initial begin
    vecs[0] = '{port: 0, r: 200, g: 200, b: 200, gray: 200, byp: 0, er: 220, eg: 220, eb: 220};
    vecs[1] = '{port: 1, r:  50, g:  60, b:  70, gray:   0, byp: 1, er:  50, eg:  60, eb:  70};
    vecs[2] = '{port: 0, r:  50, g:  60, b:  70, gray: 100, byp: 0, er:  60, eg:  70, eb:  80};
    vecs[3] = '{port: 1, r: 250, g:  10, b: 128, gray: 100, byp: 0, er: 255, eg:  20, eb: 138};
    vecs[4] = '{port: 0, r: 255, g:   0, b:   1, gray: 255, byp: 1, er: 255, eg:   0, eb:   1};
    vecs[5] = '{port: 1, r:  10, g:  10, b:  10, gray:  10, byp: 0, er:  11, eg:  11, eb:  11};

    cyc = 0; valid_pct = '{100, 100}; rdy_pct = 100; byp_mode = 0;
    clear_model();
    rst_n = 1'b0;
    bus.iReq0_valid = 1'b1; bus.iReq1_valid = 1'b1;
    bus.iReq0_R = 8'd0; bus.iReq0_G = 8'd0; bus.iReq0_B = 8'd0; bus.iReq0_gray = 8'd0; bus.iReq0_last = 1'b0;
    bus.iReq1_R = 8'd0; bus.iReq1_G = 8'd0; bus.iReq1_B = 8'd0; bus.iReq1_gray = 8'd0; bus.iReq1_last = 1'b0;
    bus.iBypass = 1'b0; bus.iRsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0", 32'(bus.oReq0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.oReq1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.oRsp_valid), 32'd0);
    chk("rst_rsp_data", 32'({bus.oRsp_R, bus.oRsp_G, bus.oRsp_B, bus.oRsp_id, bus.oRsp_last}), 32'd0);
    chk("rst_dp", 32'({bus.oDp_R, bus.oDp_G, bus.oDp_B, bus.oDp_gray}), 32'd0);
    do_reset();

    // Basic path: 3-beat line, 2-cycle latency, last on the third result
    push_line(0, 3, 8'd200, 8'd200, 8'd200, 8'd200);
    run_until_idle(20);
    chk("basic_rsp_count", 32'(rsp_id_log.size()), 32'd3);
    if (acc_cyc_log.size() > 0 && rsp_cyc_log.size() > 0)
      chk("basic_latency", 32'(rsp_cyc_log[0] - acc_cyc_log[0]), 32'd2);
    chk("basic_last_rgb", 32'({last_r, last_g, last_b, last_id, last_last}),
        32'({8'd220, 8'd220, 8'd220, 1'b0, 1'b1}));

    // Table of single-beat lines
    for (int i = 0; i < 6; i++) begin
      byp_mode = vecs[i].byp ? 1 : 0;
      push_line(vecs[i].port, 1, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].gray);
      run_until_idle(20);
      chk($sformatf("vec%0d_rgb", i), 32'({last_r, last_g, last_b}),
          32'({vecs[i].er, vecs[i].eg, vecs[i].eb}));
      chk($sformatf("vec%0d_id_last", i), 32'({last_id, last_last}),
          32'({1'(vecs[i].port), 1'b1}));
    end
    byp_mode = 0;

    // Round-robin: both request from reset, 2-beat lines
    do_reset();
    push_line(0, 2, 8'd1, 8'd2, 8'd3, 8'd0);
    push_line(0, 2, 8'd4, 8'd5, 8'd6, 8'd0);
    push_line(1, 2, 8'd7, 8'd8, 8'd9, 8'd0);
    run_until_idle(40);
    exp_ids = '{0, 0, 1, 1, 0, 0};
    chk("rr_rsp_count", 32'(rsp_id_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < rsp_id_log.size(); i++)
      chk($sformatf("rr_id%0d", i), 32'(rsp_id_log[i]), 32'(exp_ids[i]));
    exp_ids = '{0, 1, 3, 4, 6, 7};
    for (int i = 0; i < 6 && i < acc_cyc_log.size(); i++)
      chk($sformatf("rr_accept_slot%0d", i), 32'(acc_cyc_log[i] - acc_cyc_log[0]), 32'(exp_ids[i]));

    // Burst cap: port0 streams 6 beats, port1 waits with one beat
    do_reset();
    push_line(0, 6, 8'd30, 8'd31, 8'd32, 8'd20);
    push_line(1, 1, 8'd40, 8'd41, 8'd42, 8'd20);
    run_until_idle(40);
    exp_ids = '{0, 0, 0, 0, 1, 0, 0};
    chk("cap_accept_count", 32'(acc_id_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < acc_id_log.size(); i++)
      chk($sformatf("cap_id%0d", i), 32'(acc_id_log[i]), 32'(exp_ids[i]));

    // Backpressure: 4 stalled cycles mid-line
    do_reset();
    push_line(0, 6, 8'd10, 8'd10, 8'd10, 8'd10);
    repeat (3) step();
    rdy_pct = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("bp_ready0_low%0d", i), 32'(smp_rdy0), 32'd0);
    end
    rdy_pct = 100;
    run_until_idle(30);
    chk("bp_rsp_count", 32'(rsp_id_log.size()), 32'd6);

    // Reset with both stages full
    do_reset();
    push_line(0, 6, 8'd77, 8'd78, 8'd79, 8'd0);
    rdy_pct = 0;
    repeat (4) step();
    chk("pre_rst_rsp_valid", 32'(bus.oRsp_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp", 32'({bus.oRsp_valid, bus.oRsp_R, bus.oRsp_G, bus.oRsp_B}), 32'd0);
    chk("mid_rst_dp", 32'({bus.oDp_R, bus.oDp_gray}), 32'd0);
    chk("mid_rst_ready0", 32'(bus.oReq0_ready), 32'd0);
    bus.iReq0_valid = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_pct = 100;
    push_line(1, 1, 8'd5, 8'd5, 8'd5, 8'd0);
    push_line(0, 1, 8'd6, 8'd6, 8'd6, 8'd0);
    run_until_idle(20);
    if (acc_id_log.size() > 0) chk("post_rst_first_grant", 32'(acc_id_log[0]), 32'd0);

    // Randomized traffic with random valid, ready and bypass
    do_reset();
    valid_pct = '{70, 70}; rdy_pct = 70; byp_mode = 2;
    for (int l = 0; l < 15; l++) begin
      push_line(0, int'($urandom_range(1, 6)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      push_line(1, int'($urandom_range(1, 6)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    run_until_idle(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gau_share_arb.md
Name: gau_share_arb

Overview:
- Shares one combinational colour-adjust unit (GAU_RGB, instantiated by the parent) between two pixel-stream requesters: port 0 is the live camera path, port 1 is the frame-buffer/stylised path.
- Grants whole lines round-robin. A burst cap prevents starvation.
- Registers operands in front of the shared unit and results behind it, with valid/ready backpressure.
- Returns each result tagged with the requester id.

Parameters:
- MAX_BURST, 640, maximum beats per grant before forced release; legal range 2..4095.
- CW, $clog2(MAX_BURST), width of the burst counter.

Ports:
- iCLK  in  1  clock
- iRST_N  in  1  asynchronous active-low reset
- iBypass  in  1  1 = pass operand RGB unchanged; sampled per beat
- iReq0_valid / iReq1_valid  in  1  requester beat valid
- oReq0_ready / oReq1_ready  out  1  requester beat accepted when valid&ready
- iReq0_R/G/B/gray, iReq1_R/G/B/gray  in  8 each  pixel operands
- iReq0_last / iReq1_last  in  1  last pixel of line
- oDp_R/G/B/gray  out  8 each  operands to shared unit (= stage-1 regs)
- iDp_R/G/B  in  8 each  shared unit results (combinational from oDp_*)
- oRsp_valid  out  1  result valid
- iRsp_ready  in  1  downstream accept
- oRsp_R/G/B  out  8 each  result pixel
- oRsp_id  out  1  originating requester
- oRsp_last  out  1  last flag carried through

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr pointer=0, counter=0.
  - s1/s2 valids=0, all data regs=0.
  - oReqN_ready=0, oRsp_*=0.
- Pipeline enables:
  - s2_en = !s2_v | iRsp_ready.
  - s1_en = !s1_v | s2_en.
  - oReqN_ready = s1_en & (state==GRANTN). This is combinational from iRsp_ready; no other comb input→output paths.
- Stage 1, on accept: loads R,G,B,gray,id,last,bypass; s1_v=1. On s1_en with no accept: s1_v=0.
- Stage 2, on s2_en: loads s1 contents; s2_v=s1_v. Stage-2 RGB = s1 bypass ? s1 RGB : iDp RGB.
- Latency: a beat accepted at edge k gives oRsp_valid=1 after edge k+1. Full throughput is one beat per cycle. Data is held stable while oRsp_valid & !iRsp_ready.
- FSM IDLE/GRANT0/GRANT1:
  - IDLE, neither valid: stay.
  - IDLE, one valid: grant that one.
  - IDLE, both valid: grant rr pointer.
  - IDLE asserts no ready, so there is one bubble per grant.
  - GRANTN, each accepted beat: counter+1.
  - Release to IDLE on the accepted beat with last=1 or counter==MAX_BURST-1. On release: counter=0, rr=~N.
  - A granted requester that drops valid keeps the grant; there is no timeout.
- Simultaneous events:
  - Release and a new request in the same cycle: release wins; the grant is decided in IDLE next cycle.
  - Backpressure during release: a non-accepted beat is not counted and does not release.
- iBypass: a change mid-line applies per beat, from the next accepted beat.
- Reset mid-line: in-flight beats are discarded; requesters must restart the line.
- Arithmetic: no widening. All values are 8-bit pass-through; counter is CW bits and never wraps because release occurs at MAX_BURST-1.

Decomposition:
- Shared package gau_pkg:
  - state enum {IDLE, GRANT0, GRANT1}.
  - Pixel struct {r,g,b,gray}.
  - Constant PIX_W=8.
- One natural sub-module: gau_pipe_reg, a single valid/ready register slice used twice (stage 1 and stage 2) with a data-width parameter.
- The FSM and counter stay in the top module.

Test Plan:
- Basic path: req0 sends 3 beats, R=G=B=gray=200, last on the 3rd; shared unit is GAU_RGB; iRsp_ready=1 → 3 results R=G=B=220, id=0, last on 3rd, first one 2 cycles after its accept, then back to IDLE.
- Arbitration: both valid from reset, each sending 2-beat lines → order is req0 line, bubble, req1 line, bubble, req0; oRsp_id sequence 0,0,1,1,0,0.
- Backpressure: iRsp_ready=0 for 4 cycles mid-line (values 10/10/10/10 → 0) → oRsp data stable, at most 2 beats in flight, oReq0_ready low; no loss or duplication after release.
- Burst cap: MAX_BURST=4, req0 streams with last=0 and req1 waiting → grant switches after the 4th accepted beat; req0 resumes after req1's line.
- Bypass: iBypass=1, pixel R=50,G=60,B=70,gray=0 → result 50/60/70. Toggle to 0 mid-line → following beats are adjusted.
- Reset: assert iRST_N low mid-line with s1 and s2 full → outputs 0 immediately; after release, state=IDLE, rr=0, first grant goes to req0 when both request.
